// File: rtl/tdm_demux4_if.sv
// Handshake and lane bus between a TDM sample source/word consumer and tdm_demux4.
interface tdm_demux4_if #(
  parameter int DATA_W = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic                  sel_mode;
  logic [1:0]            sel_in;
  logic                  frame_start;
  logic [3:0]            lane_strobe;
  logic [4*DATA_W-1:0]   out_lanes;
  logic                  word_valid;
  logic                  word_ready;

  modport master (
    output in_valid, in_data, sel_mode, sel_in, frame_start, word_ready,
    input  in_ready, lane_strobe, out_lanes, word_valid
  );

  modport slave (
    input  in_valid, in_data, sel_mode, sel_in, frame_start, word_ready,
    output in_ready, lane_strobe, out_lanes, word_valid
  );
endinterface

// File: rtl/tdm_demux4.sv
// 1-to-4 TDM demux: steers accepted samples into 4 lane registers (1 clk latency) and
// offers the full word via valid/ready; in_ready drops while a word waits unconsumed.
module tdm_demux4 #(
  parameter int DATA_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  tdm_demux4_if.slave bus
);
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [0:0]          state;
  logic [1:0]          slot_cnt;
  logic [3:0]          fill;
  logic [3:0]          strobe;
  logic [4*DATA_W-1:0] lanes;

  logic       accept;
  logic [1:0] tgt;
  logic [3:0] tgt_oh;
  logic [3:0] fill_base;
  logic [3:0] fill_nxt;
  logic       complete;

  assign bus.in_ready    = (state == FILL) | bus.word_ready;
  assign bus.word_valid  = (state == FULL);
  assign bus.lane_strobe = strobe;
  assign bus.out_lanes   = lanes;

  assign accept    = bus.in_valid & bus.in_ready;
  assign tgt       = bus.frame_start ? 2'd0 : (bus.sel_mode ? slot_cnt : bus.sel_in);
  assign tgt_oh    = 4'b0001 << tgt;
  // frame_start wipes the mask before the current write lands
  assign fill_base = bus.frame_start ? 4'b0000 : fill;
  assign fill_nxt  = accept ? (fill_base | tgt_oh) : fill_base;
  assign complete  = accept & (fill_nxt == 4'b1111);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      slot_cnt <= 2'd0;
      fill     <= 4'b0000;
      strobe   <= 4'b0000;
      lanes    <= '0;
    end else begin
      strobe <= accept ? tgt_oh : 4'b0000;

      for (int k = 0; k < 4; k++) begin
        if (accept && (tgt == 2'(k))) begin
          lanes[k*DATA_W +: DATA_W] <= bus.in_data;
        end
      end

      if (bus.frame_start) begin
        slot_cnt <= accept ? 2'd1 : 2'd0;
      end else if (accept && bus.sel_mode) begin
        slot_cnt <= slot_cnt + 2'd1;
      end

      fill <= complete ? 4'b0000 : fill_nxt;

      if (complete) begin
        state <= FULL;
      end else if ((state == FULL) && bus.word_ready) begin
        state <= FILL;
      end
    end
  end
endmodule
